// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encoding, oversampling default
// and the 8N1 frame constants used by the receiver and its synchroniser.
package uart_rx_pkg;

  // Oversampling rate shared with the baud tick generator.
  localparam int OVERSAMPLE_DEF = 16;

  // 8N1 frame: 8 data bits, no parity, one stop bit.
  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK_WAIT = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line. The chain resets
// to the line idle level so a reset never fabricates a start edge.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage further down the chain each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops, reset to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver. Qualifies the start bit at its middle,
// samples data bits mid-bit LSB first, checks the stop bit and hands each
// byte to the host through a valid/ready holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = FRAME_DATA_BITS,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Start bit is re-checked half a bit in; after that counter clears, every
  // full wrap of the counter lands in the middle of the next bit.
  localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q,       state_d;
  logic [TICK_W-1:0]    tick_cnt_q,    tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,     bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,       shift_d;
  logic [DATA_BITS-1:0] rx_data_q,     rx_data_d;
  logic                 rx_valid_q,    rx_valid_d;
  logic                 rx_busy_q,     rx_busy_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 byte_done;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (LINE_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  // Next-state logic for the frame FSM, counters and host-side register.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = 1'b0;
    overrun_err_d = 1'b0;
    byte_done     = 1'b0;

    // The counter only moves on tick clocks and wraps on its own.
    if (rx_baud_tick && (state_q != ST_IDLE)) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_s == START_LEVEL) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (rx_baud_tick && (tick_cnt_q == MID_START)) begin
          tick_cnt_d = '0;
          if (rx_s == START_LEVEL) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (rx_baud_tick && (tick_cnt_q == LAST_TICK)) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (rx_baud_tick && (tick_cnt_q == LAST_TICK)) begin
          if (rx_s == STOP_LEVEL) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = ST_BREAK_WAIT;
          end
        end
      end
      ST_BREAK_WAIT: begin
        // Hold off until the line returns high so a break is not re-read
        // as a stream of frames.
        if (rx_s == LINE_IDLE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Host handshake: an accept clears valid unless a new byte lands in
    // the same clock; a landing byte with no accept flags an overrun.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (byte_done) begin
      rx_data_d     = shift_q;
      rx_valid_d    = 1'b1;
      overrun_err_d = rx_valid_q && !rx_ready;
    end

    rx_busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_busy_q     <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_busy_q     <= rx_busy_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Payload shift register; its contents only matter once a frame completes.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = rx_busy_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames at a fixed bit period built
// from a local 16x tick source and compares received bytes and error pulses
// against a queue-based model of what the line carried.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = TICK_DIV * OVS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int div_cnt = 0;

  uart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (OVS),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_baud_tick (rx_baud_tick),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .framing_err  (framing_err),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  // 16x tick source: one-clock pulse every TICK_DIV clocks.
  always @(posedge clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt      <= 0;
      rx_baud_tick <= 1'b1;
    end else begin
      div_cnt      <= div_cnt + 1;
      rx_baud_tick <= 1'b0;
    end
  end

  // Observe host transfers and pulses half a cycle before the edge that acts.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (framing_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (rx_busy) busy_cnt++;
    end
  end

  function automatic logic [7:0] peek(int idx);
    if (idx < got.size()) return got[idx];
    return 8'hxx;
  endfunction

  task automatic wait_clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic v);
    rx_serial = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(logic [7:0] b, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    n_checks++;
    if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    n_checks++;
    if (framing_err !== 1'b0) begin n_errors++; $display("FAIL reset_framing_err: got %b expected 0", framing_err); end
    n_checks++;
    if (overrun_err !== 1'b0) begin n_errors++; $display("FAIL reset_overrun_err: got %b expected 0", overrun_err); end
    rst = 1'b0;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_basic();
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int b0 = busy_cnt;
    int busy_len;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_clks(BIT_CLKS);
    busy_len = busy_cnt - b0;
    n_checks++;
    if (got.size() - g0 !== 1) begin n_errors++; $display("FAIL basic_count: got %0d bytes expected 1", got.size() - g0); end
    n_checks++;
    if (peek(g0) !== 8'hA5) begin n_errors++; $display("FAIL basic_data: got %h expected a5", peek(g0)); end
    n_checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL basic_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    // 9.5 bit periods of busy, give or take one tick of phase.
    n_checks++;
    if (busy_len < 596 || busy_len > 620) begin
      n_errors++; $display("FAIL basic_busy_len: got %0d clks expected about 608", busy_len);
    end
  endtask

  task automatic test_glitch();
    int g0 = got.size();
    int fe0 = fe_cnt;
    int b0 = busy_cnt;
    int busy_len;
    rx_ready = 1'b1;
    rx_serial = 1'b0;
    wait_clks(3 * TICK_DIV);
    rx_serial = 1'b1;
    wait_clks(8 * TICK_DIV);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_drop: got %b expected 0", rx_busy); end
    wait_clks(2 * BIT_CLKS);
    busy_len = busy_cnt - b0;
    n_checks++;
    if (busy_len < 1 || busy_len > 40) begin n_errors++; $display("FAIL glitch_busy_len: got %0d clks expected 1..40", busy_len); end
    n_checks++;
    if (got.size() - g0 !== 0 || fe_cnt - fe0 !== 0) begin
      n_errors++; $display("FAIL glitch_quiet: got bytes=%0d fe=%0d expected 0 0", got.size() - g0, fe_cnt - fe0);
    end
  endtask

  task automatic test_framing();
    int g0 = got.size();
    int fe0 = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    wait_clks(2 * BIT_CLKS);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_errors++; $display("FAIL break_busy: got %b expected 1", rx_busy); end
    rx_serial = 1'b1;
    wait_clks(BIT_CLKS);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL break_release: got %b expected 0", rx_busy); end
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_errors++; $display("FAIL framing_pulses: got %0d expected 1", fe_cnt - fe0); end
    n_checks++;
    if (got.size() - g0 !== 0) begin n_errors++; $display("FAIL framing_no_byte: got %0d bytes expected 0", got.size() - g0); end
    send_frame(8'h5A, 1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (got.size() - g0 !== 1 || peek(g0) !== 8'h5A) begin
      n_errors++; $display("FAIL framing_recover: got n=%0d data=%h expected 1 5a", got.size() - g0, peek(g0));
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (got.size() - g0 !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d expected 2", got.size() - g0); end
    n_checks++;
    if (peek(g0) !== 8'h00 || peek(g0 + 1) !== 8'hFF) begin
      n_errors++; $display("FAIL b2b_data: got %h %h expected 00 ff", peek(g0), peek(g0 + 1));
    end
    n_checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL b2b_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int g0 = got.size();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      wait_clks($urandom_range(0, 2) * (BIT_CLKS / 2));
    end
    wait_clks(BIT_CLKS);
    n_checks++;
    if (got.size() - g0 !== exp_q.size()) begin
      n_errors++; $display("FAIL rand_count: got %0d expected %0d", got.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (peek(g0 + i) !== exp_q[i]) begin
        n_errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, peek(g0 + i), exp_q[i]);
      end
    end
    n_checks++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      n_errors++; $display("FAIL rand_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_overrun();
    int g0 = got.size();
    int ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (ov_cnt - ov0 !== 1) begin n_errors++; $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - ov0); end
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      n_errors++; $display("FAIL overrun_hold: got valid=%b data=%h expected 1 22", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL overrun_accept: got valid=%b expected 0", rx_valid); end
    n_checks++;
    if (got.size() - g0 !== 1 || peek(g0) !== 8'h22) begin
      n_errors++; $display("FAIL overrun_taken: got n=%0d data=%h expected 1 22", got.size() - g0, peek(g0));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int g0;
    int fe0;
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_clks(BIT_CLKS);
    // Bits 4..7 high so nothing after the reset looks like a start edge.
    b = 8'hF0 | 8'($urandom_range(0, 15));
    g0 = got.size();
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx_serial = b[4];
    wait_clks(BIT_CLKS / 2);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_busy !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h busy=%b fe=%b ov=%b expected 0 00 0 0 0",
               rx_valid, rx_data, rx_busy, framing_err, overrun_err);
    end
    wait_clks(BIT_CLKS / 2 - 1);
    for (int i = 5; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (rx_valid !== 1'b0 || fe_cnt - fe0 !== 0) begin
      n_errors++; $display("FAIL midreset_tail: got valid=%b fe=%0d expected 0 0", rx_valid, fe_cnt - fe0);
    end
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1);
    wait_clks(BIT_CLKS);
    n_checks++;
    if (got.size() - g0 !== 1 || peek(g0) !== 8'hC3) begin
      n_errors++; $display("FAIL midreset_next: got n=%0d data=%h expected 1 c3", got.size() - g0, peek(g0));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_random();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
